// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder and future sibling responders.
package dm_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_BUSY = BUSY,
      ST_DONE = DONE
   } dm_state_e;

   typedef enum logic [1:0] {
      DM_ERR_NONE  = 2'd0,
      DM_ERR_RANGE = 2'd1,
      DM_ERR_KIND  = 2'd2
   } dm_err_e;

   // A request must name exactly one of read/write; kind errors take precedence.
   function automatic dm_err_e classify(input logic rd, input logic wr, input logic in_range);
      if (rd == wr)
         return DM_ERR_KIND;
      else if (!in_range)
         return DM_ERR_RANGE;
      else
         return DM_ERR_NONE;
   endfunction

   // Counter preload for a given latency: DM_ready appears LAT cycles after accept.
   function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/dm_sram.sv
// Single-port synchronous word array with registered read (read-before-write).
module dm_sram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is never cleared; read port samples every cycle.
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dm_responder.sv
// Data-memory slave: accepts one DM_* request, waits a programmable latency,
// then pulses DM_ready (with DM_error for rejected requests).
module dm_responder
   import dm_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 1024,
   parameter int READ_LAT  = 2,
   parameter int WRITE_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              DM_enable,
   input  logic              DM_read,
   input  logic              DM_write,
   input  logic [ADDR_W-1:0] DM_address,
   input  logic [DATA_W-1:0] DM_in,
   output logic [DATA_W-1:0] DM_out,
   output logic              DM_ready,
   output logic              DM_error,
   output logic              DM_busy
);

   localparam int                IDX_W   = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

   dm_state_e         state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              wr_q;
   dm_err_e           err_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] data_q;

   dm_err_e           req_err;
   logic [CNT_W-1:0]  req_cnt;
   logic              sram_we;
   logic [IDX_W-1:0]  sram_addr;
   logic [DATA_W-1:0] sram_rdata;

   assign req_err = classify(DM_read, DM_write, {1'b0, DM_address} < DEPTH_C);
   assign req_cnt = (req_err != DM_ERR_NONE) ? lat_to_cnt(1) :
                    DM_read                  ? lat_to_cnt(READ_LAT) :
                                               lat_to_cnt(WRITE_LAT);

   // In IDLE the array is pre-read at the incoming address so a 1-cycle read has
   // data ready; afterwards it follows the captured index, immune to input glitches.
   assign sram_addr = (state == ST_IDLE) ? DM_address[IDX_W-1:0] : idx_q;

   dm_sram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_sram (
      .clk   (clk),
      .we    (sram_we),
      .addr  (sram_addr),
      .wdata (data_q),
      .rdata (sram_rdata)
   );

   // Control state, wait-state counter, request kind/error and read data register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         wr_q   <= 1'b0;
         err_q  <= DM_ERR_NONE;
         DM_out <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (DM_enable) begin
                  cnt   <= req_cnt;
                  wr_q  <= DM_write;
                  err_q <= req_err;
               end
            end
            ST_BUSY: begin
               if (cnt != '0)
                  cnt <= cnt - 1'b1;
               else if (!wr_q && err_q == DM_ERR_NONE)
                  DM_out <= sram_rdata;
            end
            default: ;
         endcase
      end
   end

   // Request address and write data are captured at accept; no reset needed.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && DM_enable) begin
         idx_q  <= DM_address[IDX_W-1:0];
         data_q <= DM_in;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      DM_ready  = 1'b0;
      DM_error  = 1'b0;
      DM_busy   = 1'b0;
      sram_we   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (DM_enable)
               state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            DM_busy = 1'b1;
            if (cnt == '0)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            DM_ready  = 1'b1;
            DM_error  = (err_q != DM_ERR_NONE);
            sram_we   = wr_q && (err_q == DM_ERR_NONE);
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: default instance plus a WRITE_LAT=4 instance
// used for the reset-abort scenario.
module tb_dm_responder;

   logic        clk = 1'b0;
   logic        rst, rst4;
   logic        en, en4;
   logic        DM_read, DM_write;
   logic [11:0] DM_address;
   logic [31:0] DM_in;
   logic [31:0] out0, out4;
   logic        rdy0, rdy4, err0, err4, busy0, busy4;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   dm_responder u_dut (
      .clk(clk), .rst(rst), .DM_enable(en), .DM_read(DM_read), .DM_write(DM_write),
      .DM_address(DM_address), .DM_in(DM_in), .DM_out(out0), .DM_ready(rdy0),
      .DM_error(err0), .DM_busy(busy0)
   );

   dm_responder #(.WRITE_LAT(4)) u_dut4 (
      .clk(clk), .rst(rst4), .DM_enable(en4), .DM_read(DM_read), .DM_write(DM_write),
      .DM_address(DM_address), .DM_in(DM_in), .DM_out(out4), .DM_ready(rdy4),
      .DM_error(err4), .DM_busy(busy4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble the inputs during the access, and wait (bounded)
   // for DM_ready. lat = cycles after the accept edge; -1 means no response.
   task automatic req(input bit sel, input logic rd, input logic wr, input logic [11:0] a,
                      input logic [31:0] d, output int lat, output logic er,
                      output logic [31:0] q);
      @(negedge clk);
      DM_read = rd; DM_write = wr; DM_address = a; DM_in = d;
      if (sel) en4 = 1'b1; else en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0; en4 = 1'b0;
      DM_address = ~a; DM_in = ~d; DM_read = ~rd; DM_write = ~wr;
      lat = -1; er = 1'b0; q = '0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (sel ? rdy4 : rdy0) begin
            lat = k;
            er  = sel ? err4 : err0;
            q   = sel ? out4 : out0;
            break;
         end
      end
      @(posedge clk); #1;
      chk("ready_single_pulse", {31'b0, sel ? rdy4 : rdy0}, 32'd0);
   endtask

   int          lat;
   logic        er;
   logic [31:0] q;
   int          pulses;

   initial begin
      rst = 1'b0; rst4 = 1'b0; en = 1'b0; en4 = 1'b0;
      DM_read = 1'b0; DM_write = 1'b0; DM_address = '0; DM_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; rst4 = 1'b1;
      @(negedge clk);
      chk("reset_ready", {31'b0, rdy0}, 32'd0);
      chk("reset_error", {31'b0, err0}, 32'd0);
      chk("reset_busy",  {31'b0, busy0}, 32'd0);
      chk("reset_out",   out0, 32'd0);

      // Write then read back
      req(1'b0, 1'b0, 1'b1, 12'h005, 32'hDEADBEEF, lat, er, q);
      chk("wr005_lat", lat, 32'd1);
      chk("wr005_err", {31'b0, er}, 32'd0);
      req(1'b0, 1'b1, 1'b0, 12'h005, 32'h0, lat, er, q);
      chk("rd005_lat", lat, 32'd2);
      chk("rd005_err", {31'b0, er}, 32'd0);
      chk("rd005_data", q, 32'hDEADBEEF);

      // Back-to-back writes with DM_enable held high through DONE
      @(negedge clk);
      DM_read = 1'b0; DM_write = 1'b1; DM_address = 12'h010; DM_in = 32'h1; en = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (rdy0) begin
            pulses++;
            if (pulses == 1) begin
               DM_address = 12'h011; DM_in = 32'h2;
            end else begin
               en = 1'b0;
            end
         end
      end
      chk("b2b_pulses", pulses, 32'd2);
      req(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, lat, er, q);
      chk("rd010_data", q, 32'h1);
      req(1'b0, 1'b1, 1'b0, 12'h011, 32'h0, lat, er, q);
      chk("rd011_data", q, 32'h2);

      // Out-of-range read
      req(1'b0, 1'b1, 1'b0, 12'h400, 32'h0, lat, er, q);
      chk("rd400_lat", lat, 32'd1);
      chk("rd400_err", {31'b0, er}, 32'd1);
      chk("rd400_out_held", q, 32'h2);

      // Read and write both set
      req(1'b0, 1'b1, 1'b1, 12'h005, 32'h0, lat, er, q);
      chk("rdwr_lat", lat, 32'd1);
      chk("rdwr_err", {31'b0, er}, 32'd1);
      chk("rdwr_out_held", q, 32'h2);

      // Out-of-range write must not alias onto word 0x005
      req(1'b0, 1'b0, 1'b1, 12'h405, 32'h12345678, lat, er, q);
      chk("wr405_err", {31'b0, er}, 32'd1);
      req(1'b0, 1'b1, 1'b0, 12'h005, 32'h0, lat, er, q);
      chk("rd005_intact", q, 32'hDEADBEEF);

      // Inputs scrambled during BUSY (done inside req) do not affect the access
      req(1'b0, 1'b0, 1'b1, 12'h030, 32'hAAAA5555, lat, er, q);
      chk("wr030_err", {31'b0, er}, 32'd0);
      req(1'b0, 1'b1, 1'b0, 12'h030, 32'h0, lat, er, q);
      chk("rd030_data", q, 32'hAAAA5555);

      // WRITE_LAT=4 instance: seed a value, then abort a write with reset
      req(1'b1, 1'b0, 1'b1, 12'h020, 32'h11110000, lat, er, q);
      chk("wl4_lat", lat, 32'd4);
      req(1'b1, 1'b1, 1'b0, 12'h020, 32'h0, lat, er, q);
      chk("wl4_rd020_lat", lat, 32'd2);
      chk("wl4_rd020_data", q, 32'h11110000);

      @(negedge clk);
      DM_read = 1'b0; DM_write = 1'b1; DM_address = 12'h020; DM_in = 32'hCAFE; en4 = 1'b1;
      @(posedge clk); #1;
      en4 = 1'b0;
      pulses = 0;
      @(posedge clk); #1;
      if (rdy4) pulses++;
      @(posedge clk); #1;
      rst4 = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy4}, 32'd0);
      chk("abort_out", out4, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (rdy4) pulses++;
      end
      @(negedge clk);
      rst4 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (rdy4) pulses++;
      end
      chk("abort_no_ready", pulses, 32'd0);
      req(1'b1, 1'b1, 1'b0, 12'h020, 32'h0, lat, er, q);
      chk("abort_rd020_data", q, 32'h11110000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
